// File: rtl/envelope_gen.sv
// envelope_gen: ADSR envelope that scales an offset-binary oscillator sample about mid-scale
module envelope_gen #(
  parameter int OSC_DEPTH = 16,
  parameter int ENV_W     = 8,
  parameter int TICK_DIV  = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gate,
  input  logic [OSC_DEPTH-1:0] v,
  input  logic [ENV_W-1:0]     attack_rate,
  input  logic [ENV_W-1:0]     decay_rate,
  input  logic [ENV_W-1:0]     sustain_level,
  input  logic [ENV_W-1:0]     release_rate,
  output logic [OSC_DEPTH-1:0] v_out,
  output logic [ENV_W-1:0]     level,
  output logic [2:0]           state,
  output logic                 busy
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int PW = OSC_DEPTH + ENV_W + 1;
  localparam logic [ENV_W-1:0] LMAX = '1;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  logic [CW-1:0]        r_cnt;
  logic                 r_gate_d1;
  logic [2:0]           r_state, w_state;
  logic [ENV_W-1:0]     r_level, w_level;
  logic [OSC_DEPTH-1:0] r_v_out;
  logic                 w_tick, w_rise, w_fall;
  logic                 w_att_full, w_dec_done, w_rel_done;
  logic [ENV_W:0]       w_att_sum, w_dec_thr, w_g;
  logic [PW-1:0]        w_s, w_p;
  logic                 w_unused;
  assign w_tick     = r_cnt == CW'(TICK_DIV - 1);
  assign w_rise     = gate & ~r_gate_d1;
  assign w_fall     = ~gate & r_gate_d1;
  assign w_att_sum  = {1'b0, r_level} + {1'b0, attack_rate};
  assign w_dec_thr  = {1'b0, sustain_level} + {1'b0, decay_rate};
  assign w_att_full = w_att_sum >= {1'b0, LMAX};
  assign w_dec_done = {1'b0, r_level} <= w_dec_thr;
  assign w_rel_done = r_level <= release_rate;
  always_comb begin
    w_state = r_state;
    w_level = r_level;
    if (w_rise)
      w_state = S_ATTACK;
    else if (w_fall && r_state inside {S_ATTACK, S_DECAY, S_SUSTAIN})
      w_state = S_RELEASE;
    else
      case (r_state)
        S_ATTACK: if (w_tick) begin
          w_state = w_att_full ? S_DECAY : S_ATTACK;
          w_level = w_att_full ? LMAX : w_att_sum[ENV_W-1:0];
        end
        S_DECAY: if (w_tick) begin
          w_state = w_dec_done ? S_SUSTAIN : S_DECAY;
          w_level = w_dec_done ? sustain_level : r_level - decay_rate;
        end
        S_SUSTAIN: w_level = sustain_level;
        S_RELEASE: if (w_tick) begin
          w_state = w_rel_done ? S_IDLE : S_RELEASE;
          w_level = w_rel_done ? '0 : r_level - release_rate;
        end
        default: begin
          w_state = S_IDLE;
          w_level = '0;
        end
      endcase
  end
  // Full level maps to a gain of exactly 2^ENV_W so the product is unity after the shift
  assign w_g = (r_level == LMAX) ? {1'b1, {ENV_W{1'b0}}} : {1'b0, r_level};
  assign w_s = {{(ENV_W + 1){~v[OSC_DEPTH-1]}}, ~v[OSC_DEPTH-1], v[OSC_DEPTH-2:0]};
  assign w_p = w_s * {{(PW - ENV_W - 1){1'b0}}, w_g};
  assign w_unused = ^{w_p[PW-1], w_p[ENV_W-1:0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_gate_d1 <= 1'b0;
      r_state   <= S_IDLE;
      r_level   <= '0;
      r_v_out   <= {1'b1, {(OSC_DEPTH - 1){1'b0}}};
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + 1'b1;
      r_gate_d1 <= gate;
      r_state   <= w_state;
      r_level   <= w_level;
      r_v_out   <= {~w_p[PW-2], w_p[PW-3:ENV_W]};
    end
  end
  assign v_out = r_v_out;
  assign level = r_level;
  assign state = r_state;
  assign busy  = r_state != S_IDLE;
endmodule

// File: doc/envelope_gen.md
Name: envelope_gen

Overview:
- ADSR amplitude envelope stage directly downstream of the oscillator.
- Consumes the oscillator's offset-binary voltage sample every clock and scales it about mid-scale by an envelope level.
- The envelope level is driven by a note gate through ATTACK/DECAY/SUSTAIN/RELEASE phases.
- Output feeds the DAC/output stage.

Parameters:
OSC_DEPTH, 16, width of input and output voltage samples (offset binary; mid-scale = 2^(OSC_DEPTH-1) = silence)
ENV_W, 8, envelope level and rate width; level range 0..2^ENV_W-1
TICK_DIV, 1000, clocks per envelope update tick (10 us at 100 MHz); minimum 2

Ports:
clk  in  1  system clock (100 MHz); all logic on rising edge
rst_n  in  1  synchronous active-low reset
gate  in  1  note held (1) / released (0)
v  in  OSC_DEPTH  oscillator voltage sample, offset binary
attack_rate  in  ENV_W  level increment per tick in ATTACK
decay_rate  in  ENV_W  level decrement per tick in DECAY
sustain_level  in  ENV_W  SUSTAIN target level
release_rate  in  ENV_W  level decrement per tick in RELEASE
v_out  out  OSC_DEPTH  enveloped sample, offset binary, registered
level  out  ENV_W  current envelope level, registered
state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, level=0, prescaler=0, gate_d1=0, v_out=2^(OSC_DEPTH-1).
  - Reset applies mid-operation in any state; takes effect on that edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick=1 for the single cycle at count TICK_DIV-1.
  - Free-running from reset, independent of gate.
- Gate edge detection: gate_d1 registers gate.
  - rise = gate & ~gate_d1; fall = ~gate & gate_d1.
- Transitions (edge events take priority over tick updates in the same cycle):
  - rise, from any state: ATTACK; level unchanged (retrigger continues from current level).
  - fall, from ATTACK/DECAY/SUSTAIN: RELEASE; level unchanged.
  - ATTACK on tick: if level + attack_rate >= 2^ENV_W-1, level = max and state = DECAY; else level += attack_rate. Compute the sum at ENV_W+1 bits; no wrap. attack_rate=0 holds the level in ATTACK.
  - DECAY on tick: if level <= sustain_level + decay_rate (ENV_W+1-bit compare), level = sustain_level and state = SUSTAIN; else level -= decay_rate.
  - SUSTAIN: level = sustain_level every cycle, tick not required; live changes track.
  - RELEASE on tick: if level <= release_rate, level=0 and state=IDLE; else level -= release_rate. release_rate=0 holds the level.
  - IDLE: level=0.
- Scaling datapath (1-cycle latency):
  - s = v with MSB inverted (signed, OSC_DEPTH bits).
  - g = 2^ENV_W when level = max, else level (ENV_W+1 bits unsigned). Gives exact unity at full level.
  - p = s*g (signed, OSC_DEPTH+ENV_W+1 bits).
  - v_out(n+1) = (p >>> ENV_W) truncated to OSC_DEPTH bits, MSB inverted.
  - Uses level(n) and v(n) registered values from the same edge.
  - Mid-scale input gives mid-scale output for any level. No overflow is possible, so no saturation is needed.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Common setup: TICK_DIV=4, OSC_DEPTH=16, ENV_W=8.
1. Reset: hold rst_n=0 for 3 clks with gate=1 -> v_out=0x8000, level=0, state=0, busy=0. Release reset with gate=1 -> rise detected, state=1.
2. Attack: attack_rate=64, gate 0->1 -> level 64, 128, 192, then 255 on successive ticks; state=2 after the 4th tick.
3. Decay/sustain: decay_rate=50, sustain_level=100 -> level 205, 155, 105, then 100 with state=3; changing sustain_level to 90 gives level=90 next clk.
4. Release: from level 100, release_rate=40, gate 1->0 -> state=4; level 60, 20, 0; state=0, busy=0.
5. Scaling:
   - level=255, v=0xFFFF -> v_out=0xFFFF one clk later.
   - level=128, v=0x0000 -> v_out=0x4000.
   - any level, v=0x8000 -> v_out=0x8000.
   - level=0, v=0xFFFF -> v_out=0x8000.
6. Retrigger and edges:
   - In RELEASE at level 60 with attack_rate=64, gate 0->1 -> state=1; next tick level=124.
   - Gate rise coincident with a tick in RELEASE -> state=ATTACK and level unchanged that cycle.
   - rst_n=0 mid-ATTACK -> reset values on that edge.
